// File: rtl/dispatch_ctrl_if.sv
// Renamed-instruction type plus the rename->dispatch and dispatch->RS handshake bundles.
package types_pkg;
  localparam int PREG_W = 7;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd_new;
    logic [TAG_W-1:0]  rob_tag;
    logic [5:0]        opcode;
    logic              fu_alu;
    logic              fu_br;
    logic              fu_mem;
  } rename_data;
endpackage

interface dispatch_in_if;
  import types_pkg::*;
  logic       valid_in;
  rename_data data_in;
  logic       ready_in;

  modport master (output valid_in, data_in, input ready_in);
  modport slave  (input valid_in, data_in, output ready_in);
endinterface

interface dispatch_rs_if;
  import types_pkg::*;
  rename_data dis_data;
  logic       ps1_rdy;
  logic       ps2_rdy;
  logic       alu_valid;
  logic       alu_ready;
  logic       br_valid;
  logic       br_ready;
  logic       mem_valid;
  logic       mem_ready;

  modport master (output dis_data, ps1_rdy, ps2_rdy, alu_valid, br_valid, mem_valid,
                  input  alu_ready, br_ready, mem_ready);
  modport slave  (input  dis_data, ps1_rdy, ps2_rdy, alu_valid, br_valid, mem_valid,
                  output alu_ready, br_ready, mem_ready);
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch stage: ROB-credit gating, one-entry holding register steered to ALU/BR/MEM RS,
// and the physical-register ready scoreboard.
module dispatch_ctrl
  import types_pkg::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int CNT_W     = 5,
  parameter int NUM_PREG  = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  dispatch_in_if.slave       ren,
  input  logic               rob_retire,
  input  logic               mispredict,
  input  logic [CNT_W-1:0]   rob_count_rst,
  input  logic               wb_valid,
  input  logic [PREG_W-1:0]  wb_preg,
  dispatch_rs_if.master      rs,
  output logic [CNT_W-1:0]   rob_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_reg, state_next;
  rename_data         data_reg;
  logic               ps1_rdy_reg, ps2_rdy_reg;
  logic [CNT_W-1:0]   rob_count_reg;
  logic [NUM_PREG-1:0] sb_reg;

  logic target_ready;
  logic fire;
  logic accept;

  assign target_ready = data_reg.fu_mem ? rs.mem_ready :
                        data_reg.fu_br  ? rs.br_ready  : rs.alu_ready;
  assign fire         = (state_reg == FULL) && target_ready;
  assign ren.ready_in = !mispredict && (rob_count_reg < CNT_W'(ROB_DEPTH)) &&
                        ((state_reg == EMPTY) || fire);
  assign accept       = ren.valid_in && ren.ready_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= EMPTY;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    rs.alu_valid = 1'b0;
    rs.br_valid  = 1'b0;
    rs.mem_valid = 1'b0;
    if (mispredict) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = FULL;
        FULL:    if (fire && !accept) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
    if (state_reg == FULL) begin
      if (data_reg.fu_mem)     rs.mem_valid = 1'b1;
      else if (data_reg.fu_br) rs.br_valid  = 1'b1;
      else                     rs.alu_valid = 1'b1;
    end
  end

  // Source readiness is sampled at accept with a same-cycle writeback bypass, then only ever set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg    <= '0;
      ps1_rdy_reg <= 1'b0;
      ps2_rdy_reg <= 1'b0;
    end else if (accept) begin
      data_reg    <= ren.data_in;
      ps1_rdy_reg <= sb_reg[ren.data_in.ps1] || (wb_valid && (wb_preg == ren.data_in.ps1));
      ps2_rdy_reg <= sb_reg[ren.data_in.ps2] || (wb_valid && (wb_preg == ren.data_in.ps2));
    end else if (state_reg == FULL) begin
      if (wb_valid && (wb_preg == data_reg.ps1)) ps1_rdy_reg <= 1'b1;
      if (wb_valid && (wb_preg == data_reg.ps2)) ps2_rdy_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        rob_count_reg <= '0;
    else if (mispredict)                                 rob_count_reg <= rob_count_rst;
    else if (accept && !rob_retire)                      rob_count_reg <= rob_count_reg + CNT_W'(1);
    else if (!accept && rob_retire && rob_count_reg != '0) rob_count_reg <= rob_count_reg - CNT_W'(1);
  end

  // Preg 0 is never cleared (pd_new == 0 means no destination), so it stays ready from reset.
  for (genvar gi = 0; gi < NUM_PREG; gi++) begin : g_sb
    logic sb_clr, sb_set;
    assign sb_clr = accept && (ren.data_in.pd_new != '0) && (ren.data_in.pd_new == PREG_W'(gi));
    assign sb_set = wb_valid && (wb_preg == PREG_W'(gi));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    sb_reg[gi] <= 1'b1;
      else if (sb_clr) sb_reg[gi] <= 1'b0;
      else if (sb_set) sb_reg[gi] <= 1'b1;
    end
  end

  assign rs.dis_data = data_reg;
  assign rs.ps1_rdy  = ps1_rdy_reg;
  assign rs.ps2_rdy  = ps2_rdy_reg;
  assign rob_count   = rob_count_reg;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: per-cycle comparison against a transaction-level model
// plus literal checks at the interesting points of each scenario.
module tb_dispatch_ctrl;
  import types_pkg::*;

  localparam int ROB_DEPTH = 16;
  localparam int CNT_W     = 5;
  localparam int NUM_PREG  = 128;
  localparam int ALU = 0, BR = 1, MEM = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             rob_retire = 1'b0;
  logic             mispredict = 1'b0;
  logic [CNT_W-1:0] rob_count_rst = '0;
  logic             wb_valid = 1'b0;
  logic [6:0]       wb_preg = '0;
  logic [CNT_W-1:0] rob_count;

  dispatch_in_if ren ();
  dispatch_rs_if rs ();

  always #5 clk = ~clk;

  dispatch_ctrl #(.ROB_DEPTH(ROB_DEPTH), .CNT_W(CNT_W), .NUM_PREG(NUM_PREG)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ren           (ren),
    .rob_retire    (rob_retire),
    .mispredict    (mispredict),
    .rob_count_rst (rob_count_rst),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .rs            (rs),
    .rob_count     (rob_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rename_data mk(input int ps1, input int ps2, input int pd, input int fu);
    rename_data d;
    d         = '0;
    d.ps1     = 7'(ps1);
    d.ps2     = 7'(ps2);
    d.pd_new  = 7'(pd);
    d.rob_tag = 4'(pd);
    d.opcode  = 6'(pd + 3);
    d.fu_alu  = (fu == ALU);
    d.fu_br   = (fu == BR);
    d.fu_mem  = (fu == MEM);
    return d;
  endfunction

  // Model: one optional held instruction, an integer ROB count and a ready bit per preg.
  bit         m_full;
  rename_data m_data;
  bit         m_r1, m_r2;
  int         m_cnt;
  bit         m_sb [NUM_PREG];

  always @(negedge clk) begin
    int tgt;
    bit rdy_t, fire, exp_rdy, acc;
    if (!reset_n) begin
      m_full = 1'b0;
      m_data = '0;
      m_r1   = 1'b0;
      m_r2   = 1'b0;
      m_cnt  = 0;
      foreach (m_sb[i]) m_sb[i] = 1'b1;
    end
    tgt = !m_full ? -1 : m_data.fu_mem ? MEM : m_data.fu_br ? BR : ALU;
    chk("alu_valid", 64'(rs.alu_valid), 64'(tgt == ALU));
    chk("br_valid",  64'(rs.br_valid),  64'(tgt == BR));
    chk("mem_valid", 64'(rs.mem_valid), 64'(tgt == MEM));
    chk("rob_count", 64'(rob_count),    64'(m_cnt));
    if (!reset_n) begin
      chk("rst_dis_data", 64'(rs.dis_data), 64'(0));
      chk("rst_ps1_rdy",  64'(rs.ps1_rdy),  64'(0));
      chk("rst_ps2_rdy",  64'(rs.ps2_rdy),  64'(0));
    end else begin
      rdy_t   = (tgt == MEM) ? rs.mem_ready : (tgt == BR) ? rs.br_ready : rs.alu_ready;
      fire    = m_full && rdy_t;
      exp_rdy = !mispredict && (m_cnt < ROB_DEPTH) && (!m_full || fire);
      chk("ready_in", 64'(ren.ready_in), 64'(exp_rdy));
      if (m_full) begin
        chk("dis_data", 64'(rs.dis_data), 64'(m_data));
        chk("ps1_rdy",  64'(rs.ps1_rdy),  64'(m_r1));
        chk("ps2_rdy",  64'(rs.ps2_rdy),  64'(m_r2));
      end
      acc = ren.valid_in && exp_rdy;
      if (mispredict) begin
        m_full = 1'b0;
        m_cnt  = int'(rob_count_rst);
      end else begin
        if (acc) begin
          m_r1   = m_sb[ren.data_in.ps1] || (wb_valid && wb_preg == ren.data_in.ps1);
          m_r2   = m_sb[ren.data_in.ps2] || (wb_valid && wb_preg == ren.data_in.ps2);
          m_data = ren.data_in;
          m_full = 1'b1;
        end else if (fire) begin
          m_full = 1'b0;
        end else if (m_full) begin
          if (wb_valid && wb_preg == m_data.ps1) m_r1 = 1'b1;
          if (wb_valid && wb_preg == m_data.ps2) m_r2 = 1'b1;
        end
        if (acc && !rob_retire) m_cnt++;
        else if (!acc && rob_retire && m_cnt > 0) m_cnt--;
      end
      if (wb_valid) m_sb[wb_preg] = 1'b1;
      if (acc && ren.data_in.pd_new != 0) m_sb[ren.data_in.pd_new] = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    cyc();
    ren.valid_in  = 1'b0;
    mispredict    = 1'b1;
    rob_count_rst = '0;
    cyc();
    mispredict    = 1'b0;
  endtask

  rename_data i_alu, i_br, i_mem, i_m, i_a2;

  initial begin
    ren.valid_in = 1'b0;
    ren.data_in  = '0;
    rs.alu_ready = 1'b1;
    rs.br_ready  = 1'b1;
    rs.mem_ready = 1'b1;
    i_alu = mk(5, 6, 10, ALU);
    i_br  = mk(7, 8, 11, BR);
    i_mem = mk(9, 0, 12, MEM);
    i_m   = mk(13, 14, 20, MEM);
    i_a2  = mk(15, 16, 21, ALU);

    repeat (3) cyc();
    reset_n = 1'b1;
    #2;
    chk("lit_rst_ready_in", 64'(ren.ready_in), 64'(1));
    chk("lit_rst_rob_count", 64'(rob_count), 64'(0));

    // Steering: ALU, BR, MEM back-to-back
    cyc(); ren.valid_in = 1'b1; ren.data_in = i_alu; #2;
    chk("lit_steer_ready0", 64'(ren.ready_in), 64'(1));
    cyc(); ren.data_in = i_br; #2;
    chk("lit_steer_alu", 64'(rs.alu_valid), 64'(1));
    chk("lit_steer_alu_data", 64'(rs.dis_data), 64'(i_alu));
    chk("lit_first_ps1_rdy", 64'(rs.ps1_rdy), 64'(1));
    chk("lit_first_ps2_rdy", 64'(rs.ps2_rdy), 64'(1));
    chk("lit_steer_ready1", 64'(ren.ready_in), 64'(1));
    cyc(); ren.data_in = i_mem; #2;
    chk("lit_steer_br", 64'(rs.br_valid), 64'(1));
    chk("lit_steer_ready2", 64'(ren.ready_in), 64'(1));
    cyc(); ren.valid_in = 1'b0; rob_retire = 1'b1; #2;
    chk("lit_steer_mem", 64'(rs.mem_valid), 64'(1));
    chk("lit_steer_count", 64'(rob_count), 64'(3));
    repeat (3) cyc();
    cyc(); rob_retire = 1'b0; #2;
    chk("lit_retire_floor", 64'(rob_count), 64'(0));

    // Backpressure on MEM
    cyc(); rs.mem_ready = 1'b0; ren.valid_in = 1'b1; ren.data_in = i_m;
    for (int k = 0; k < 3; k++) begin
      cyc(); ren.data_in = i_a2; #2;
      chk("lit_bp_ready_in", 64'(ren.ready_in), 64'(0));
      chk("lit_bp_mem_valid", 64'(rs.mem_valid), 64'(1));
      chk("lit_bp_stable", 64'(rs.dis_data), 64'(i_m));
    end
    cyc(); rs.mem_ready = 1'b1; #2;
    chk("lit_bp_release", 64'(ren.ready_in), 64'(1));
    cyc(); ren.valid_in = 1'b0; #2;
    chk("lit_bp_next_alu", 64'(rs.alu_valid), 64'(1));
    chk("lit_bp_next_data", 64'(rs.dis_data), 64'(i_a2));
    flush();

    // Scoreboard: pending, wakeup, clear-wins, bypass
    ren.valid_in = 1'b1; ren.data_in = mk(1, 2, 37, ALU);
    cyc(); ren.data_in = mk(37, 3, 40, ALU);
    cyc(); ren.valid_in = 1'b0; rs.alu_ready = 1'b0; wb_valid = 1'b1; wb_preg = 7'd37; #2;
    chk("lit_sb_pending", 64'(rs.ps1_rdy), 64'(0));
    cyc(); wb_valid = 1'b0; #2;
    chk("lit_sb_wakeup", 64'(rs.ps1_rdy), 64'(1));
    cyc(); rs.alu_ready = 1'b1; ren.valid_in = 1'b1; ren.data_in = mk(5, 6, 37, ALU);
    wb_valid = 1'b1; wb_preg = 7'd37;
    cyc(); wb_valid = 1'b0; ren.data_in = mk(3, 37, 41, ALU);
    cyc(); ren.data_in = mk(37, 4, 42, ALU); wb_valid = 1'b1; wb_preg = 7'd37; #2;
    chk("lit_sb_clear_wins", 64'(rs.ps2_rdy), 64'(0));
    cyc(); ren.valid_in = 1'b0; wb_valid = 1'b0; #2;
    chk("lit_sb_bypass", 64'(rs.ps1_rdy), 64'(1));
    flush();

    // ROB full
    for (int i = 0; i < 16; i++) begin
      ren.valid_in = 1'b1; ren.data_in = mk(i, i + 1, 50 + i, ALU);
      cyc();
    end
    #2;
    chk("lit_rob_full_count", 64'(rob_count), 64'(16));
    chk("lit_rob_full_ready", 64'(ren.ready_in), 64'(0));
    cyc(); rob_retire = 1'b1; #2;
    chk("lit_rob_full_retire_ready", 64'(ren.ready_in), 64'(0));
    cyc(); ren.data_in = mk(9, 9, 70, ALU); #2;
    chk("lit_rob_after_retire", 64'(rob_count), 64'(15));
    chk("lit_rob_reopen", 64'(ren.ready_in), 64'(1));
    cyc(); rob_retire = 1'b0; ren.valid_in = 1'b0; #2;
    chk("lit_rob_retire_accept", 64'(rob_count), 64'(15));
    flush();

    // Mispredict with a full register
    for (int i = 0; i < 9; i++) begin
      ren.valid_in = 1'b1; ren.data_in = mk(i + 20, i + 30, 100 + i, i % 3);
      cyc();
    end
    mispredict = 1'b1; rob_count_rst = 5'd4; ren.data_in = mk(20, 21, 80, ALU); #2;
    chk("lit_mp_count_before", 64'(rob_count), 64'(9));
    chk("lit_mp_held_mem", 64'(rs.mem_valid), 64'(1));
    chk("lit_mp_no_accept", 64'(ren.ready_in), 64'(0));
    cyc(); mispredict = 1'b0; ren.valid_in = 1'b0; #2;
    chk("lit_mp_valids", 64'({rs.alu_valid, rs.br_valid, rs.mem_valid}), 64'(0));
    chk("lit_mp_count_after", 64'(rob_count), 64'(4));
    cyc(); ren.valid_in = 1'b1; ren.data_in = mk(1, 1, 81, BR);
    cyc(); ren.valid_in = 1'b0; #2;
    chk("lit_mp_resume_count", 64'(rob_count), 64'(5));
    chk("lit_mp_resume_br", 64'(rs.br_valid), 64'(1));

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      ren.valid_in = 1'b1; ren.data_in = mk(i, i, 60 + i, i % 3);
      cyc();
    end
    reset_n = 1'b0; #2;
    chk("lit_midrst_valids", 64'({rs.alu_valid, rs.br_valid, rs.mem_valid}), 64'(0));
    chk("lit_midrst_count", 64'(rob_count), 64'(0));
    cyc(); #2;
    chk("lit_midrst_hold", 64'(rob_count), 64'(0));
    cyc(); reset_n = 1'b1; ren.data_in = mk(50, 51, 90, ALU); #2;
    chk("lit_midrst_ready_in", 64'(ren.ready_in), 64'(1));
    cyc(); ren.valid_in = 1'b0; #2;
    chk("lit_midrst_ps1_rdy", 64'(rs.ps1_rdy), 64'(1));
    chk("lit_midrst_ps2_rdy", 64'(rs.ps2_rdy), 64'(1));
    chk("lit_midrst_alu", 64'(rs.alu_valid), 64'(1));
    chk("lit_midrst_count1", 64'(rob_count), 64'(1));
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
